// File: rtl/spi_service_frame_decoder_pkg.sv
// ServiceProtocol framing definitions shared by the SPI frame decoder and its consumers.
// Frame layout: addr word (addr byte, 8'h00), header (size byte, cmd byte), payload, checksum, packet number.
package spi_service_frame_decoder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_DATA,
      ST_CHK,
      ST_NUM
   } frame_state_t;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_CHECKSUM = 2'd1;
   localparam logic [1:0] ERR_OVERFLOW = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

   localparam int ADDR_BYTE_HI = 15;
   localparam int ADDR_BYTE_LO = 8;
   localparam int SIZE_BYTE_HI = 15;
   localparam int SIZE_BYTE_LO = 8;
   localparam int CMD_BYTE_HI  = 7;
   localparam int CMD_BYTE_LO  = 0;
   localparam int CHK_W        = 16;

   function automatic logic is_frame_start(input logic [15:0] word);
      return (word[7:0] == 8'h00) && (word[ADDR_BYTE_HI:ADDR_BYTE_LO] != 8'h00);
   endfunction

endpackage

// File: rtl/spi_service_frame_decoder.sv
// Parses ServiceProtocol frames from SPI words; header/payload/status appear one cycle after the input word.
// Input never stalls: a payload word arriving while the previous one is still pending is dropped and flagged.
module spi_service_frame_decoder
   import spi_service_frame_decoder_pkg::*;
#(
   parameter logic [7:0] ADDR    = 8'hAB,
   parameter int         TIMEOUT = 2048
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] in_data,
   input  logic        in_request,
   output logic        hdr_valid,
   output logic [7:0]  hdr_cmd,
   output logic [7:0]  hdr_size,
   output logic [15:0] out_data,
   output logic        out_request,
   input  logic        out_done,
   output logic        pkt_ok,
   output logic        pkt_err,
   output logic [1:0]  err_code,
   output logic [15:0] pkt_num
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   frame_state_t     state;
   logic             own;
   logic [CHK_W-1:0] sum;
   logic [7:0]       size;
   logic [7:0]       data_cnt;
   logic [CNT_W-1:0] idle_cnt;
   logic             pending;
   logic             ovf_flag;
   logic             chk_flag;

   // out_done in the same cycle as a new payload word frees the slot first
   logic pend_kept;
   logic timeout_hit;

   assign pend_kept   = pending & ~out_done;
   assign timeout_hit = (state != ST_IDLE) && !in_request &&
                        (idle_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         own         <= 1'b0;
         sum         <= '0;
         size        <= '0;
         data_cnt    <= '0;
         idle_cnt    <= '0;
         pending     <= 1'b0;
         ovf_flag    <= 1'b0;
         chk_flag    <= 1'b0;
         hdr_valid   <= 1'b0;
         hdr_cmd     <= '0;
         hdr_size    <= '0;
         out_data    <= '0;
         out_request <= 1'b0;
         pkt_ok      <= 1'b0;
         pkt_err     <= 1'b0;
         err_code    <= ERR_NONE;
         pkt_num     <= '0;
      end else begin
         hdr_valid   <= 1'b0;
         out_request <= 1'b0;
         pkt_ok      <= 1'b0;
         pkt_err     <= 1'b0;
         pending     <= pend_kept;

         if (state == ST_IDLE || in_request) begin
            idle_cnt <= '0;
         end else begin
            idle_cnt <= idle_cnt + 1'b1;
         end

         if (timeout_hit) begin
            state    <= ST_IDLE;
            idle_cnt <= '0;
            if (own) begin
               pkt_err  <= 1'b1;
               err_code <= ERR_TIMEOUT;
               pkt_num  <= '0;
            end
         end else if (in_request) begin
            case (state)
               ST_IDLE: begin
                  // frame starts are only recognised here, so payload like AB00 never resyncs
                  if (is_frame_start(in_data)) begin
                     own      <= (in_data[ADDR_BYTE_HI:ADDR_BYTE_LO] == ADDR);
                     sum      <= in_data;
                     ovf_flag <= 1'b0;
                     chk_flag <= 1'b0;
                     data_cnt <= '0;
                     state    <= ST_HDR;
                  end
               end
               ST_HDR: begin
                  sum  <= sum + in_data;
                  size <= in_data[SIZE_BYTE_HI:SIZE_BYTE_LO];
                  if (own) begin
                     hdr_valid <= 1'b1;
                     hdr_cmd   <= in_data[CMD_BYTE_HI:CMD_BYTE_LO];
                     hdr_size  <= in_data[SIZE_BYTE_HI:SIZE_BYTE_LO];
                  end
                  state <= (in_data[SIZE_BYTE_HI:SIZE_BYTE_LO] != 8'h00) ? ST_DATA : ST_CHK;
               end
               ST_DATA: begin
                  sum <= sum + in_data;
                  if (own) begin
                     if (pend_kept) begin
                        ovf_flag <= 1'b1;
                     end else begin
                        out_data    <= in_data;
                        out_request <= 1'b1;
                        pending     <= 1'b1;
                     end
                  end
                  if (data_cnt == size - 8'd1) begin
                     state <= ST_CHK;
                  end else begin
                     data_cnt <= data_cnt + 8'd1;
                  end
               end
               ST_CHK: begin
                  if (in_data != sum) begin
                     chk_flag <= 1'b1;
                  end
                  state <= ST_NUM;
               end
               ST_NUM: begin
                  state <= ST_IDLE;
                  if (own) begin
                     pkt_num <= in_data;
                     if (ovf_flag || chk_flag) begin
                        pkt_err  <= 1'b1;
                        err_code <= ovf_flag ? ERR_OVERFLOW : ERR_CHECKSUM;
                     end else begin
                        pkt_ok   <= 1'b1;
                        err_code <= ERR_NONE;
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/spi_service_frame_decoder.md
Name: spi_service_frame_decoder

Overview:
- Consumes 16-bit words pushed by the SPI slave receiver and parses ServiceProtocol frames: addr, size/cmd, payload, checksum, packet number.
- Frames whose address matches the block address are forwarded to the command handler as a header pulse, a payload push stream and an end-of-frame status.
- Frames for other addresses are tracked silently so the decoder stays in sync.
- Sits directly upstream of the command/queue logic inside one milSpi block; two instances with different ADDR share one SPI bus.

Parameters:
- ADDR, 8'hAB, block address matched against the high byte of the frame's first word.
- TIMEOUT, 2048, maximum clk cycles between words inside a frame before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_data  in  16  word from SPI receiver
- in_request  in  1  one-cycle pulse, in_data valid
- hdr_valid  out  1  one-cycle pulse, own header decoded
- hdr_cmd  out  8  command code (low byte of word 1)
- hdr_size  out  8  payload word count (high byte of word 1)
- out_data  out  16  payload word
- out_request  out  1  one-cycle pulse, out_data valid
- out_done  in  1  consumer has taken the pending payload word
- pkt_ok  out  1  one-cycle pulse, own frame complete and valid
- pkt_err  out  1  one-cycle pulse, own frame aborted or invalid
- err_code  out  2  0 none, 1 checksum, 2 overflow, 3 timeout; valid with pkt_err
- pkt_num  out  16  packet number word; valid with pkt_ok/pkt_err

Behaviour:
- Reset (rst sampled high on a clk edge): state IDLE; all outputs 0; sum, counters and pending flag cleared. A mid-frame reset drops the frame with no pkt_err.
- Input is never stalled; every in_request word is consumed in the same cycle.
- Frame start: in IDLE, a word with low byte 8'h00 and high byte != 0 starts a frame. own = (high byte == ADDR). Any other word in IDLE is discarded.
- States and transitions:
  - IDLE -> HDR on frame start.
  - HDR -> DATA if size > 0, else HDR -> CHK.
  - DATA counts size words, then -> CHK.
  - CHK -> NUM.
  - NUM -> IDLE.
- sum: 16-bit, modulo 2^16. Loaded with the addr word, then adds the header word and each payload word. Example: AC00 + 00B0 = ACB0.
- CHK: received word != sum sets the checksum error flag.
- NUM: word latched into pkt_num.
- Header output (own only): hdr_valid, hdr_cmd and hdr_size asserted the cycle after the header word's in_request.
- Payload output (own only): out_request pulses and out_data is registered the cycle after each payload word's in_request. Word stays pending until out_done.
  - A new payload word arriving while a word is pending sets the overflow flag and is dropped; the pending word is kept.
  - out_done on the same cycle as a new word clears pending first, so no overflow.
- End of frame (own only): the cycle after the NUM word, pkt_ok if no error flag, else pkt_err.
  - err_code priority: overflow over checksum.
- Timeout: an idle counter runs in HDR/DATA/CHK/NUM and clears on each in_request. When it reaches TIMEOUT: return to IDLE; pkt_err with err_code 3 and pkt_num 0 if own, silent if foreign.
- Foreign frames: the same states are walked and the timeout applies, but no output is ever asserted.
- Frame-start words are recognised only in IDLE, so payload words such as AB00 never resync mid-frame.

Decomposition:
- Shared package (e.g. spiServiceProtocol): frame-state enum, err_code constants, ADDR_BYTE/SIZE_BYTE field positions, checksum width.
- No sub-module is needed. Optionally a small frame_checksum accumulator; inline is preferred.

Test Plan:
- ADDR=AC; push AC00, 00B0, ACB0, 0000 -> hdr_valid cmd=B0 size=00; no out_request; pkt_ok, pkt_num=0000.
- ADDR=AB; push AB00, 08A2, FFA1, 0001, FFA3, 0002, FFA3, AB45, FFA3, FFA1, 5D15, 0003, with out_done answered -> hdr_valid cmd=A2 size=08; 8 out pushes in order FFA1…FFA1; pkt_ok, pkt_num=0003.
- Same frame with checksum 5D16 -> 8 pushes, then pkt_err err_code=1.
- ADDR=AB; push the AC status frame, then the AB frame -> no outputs for AC; AB frame decoded exactly as in the second scenario.
- AB frame with out_done held low -> first word pending, pkt_err err_code=2.
- Stop after 3 payload words for TIMEOUT cycles -> pkt_err err_code=3. Repeat with rst pulsed mid-frame -> no pkt_err, next frame decodes OK.
